// File: rtl/alu_sequencer_if.sv
// Request and ALU-side signal bundle for the ALU issue/writeback sequencer.
// master: the sequencer view (accepts requests, drives the ALU operands).
// slave:  the surrounding view (decoder drives requests, ALU returns results).
interface alu_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [AW-1:0]    req_rd;
  logic [AW-1:0]    req_ra;
  logic [AW-1:0]    req_rb;
  logic             req_imm_en;
  logic [WIDTH-1:0] req_imm;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_sel;
  logic             alu_carry_in;
  logic [WIDTH-1:0] alu_out;
  logic             alu_carry;
  logic             alu_sign;
  logic             alu_overflow;
  logic             alu_zero;

  modport master (
    input  req_valid, req_op, req_rd, req_ra, req_rb, req_imm_en, req_imm,
    output req_ready,
    output alu_a, alu_b, alu_sel, alu_carry_in,
    input  alu_out, alu_carry, alu_sign, alu_overflow, alu_zero
  );

  modport slave (
    output req_valid, req_op, req_rd, req_ra, req_rb, req_imm_en, req_imm,
    input  req_ready,
    input  alu_a, alu_b, alu_sel, alu_carry_in,
    output alu_out, alu_carry, alu_sign, alu_overflow, alu_zero
  );
endinterface

// File: rtl/alu_sequencer.sv
// Issue/writeback controller for the 16-bit combinational ALU.
// Reads operands from an internal register file, drives registered ALU
// inputs, latches result and flags, writes back and pulses done.
//
// state | meaning
// IDLE  | ready for a request; accepting one loads the ALU operand registers
// EXEC  | ALU settles; result and flags are captured at the end of the cycle
// WB    | done is high; register file and flag register update at the end
module alu_sequencer #(
  parameter int NREGS = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  alu_sequencer_if.master          bus,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  output logic [3:0]               flags,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [WIDTH-1:0]         dbg_data
);

  localparam int AW = $clog2(NREGS);
  localparam logic [3:0] OP_CMP = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic             accept;
  logic             capture;
  logic             writeback;

  logic [WIDTH-1:0] regs [NREGS];
  logic [AW-1:0]    rd_q;
  logic             no_wb_q;
  logic [3:0]       pend_flags;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic and per-state strobes
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    capture       = 1'b0;
    writeback     = 1'b0;
    bus.req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        capture = 1'b1;
        state_d = WB;
      end
      WB: begin
        writeback = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand issue, result capture and writeback datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      bus.alu_a        <= '0;
      bus.alu_b        <= '0;
      bus.alu_sel      <= '0;
      bus.alu_carry_in <= 1'b0;
      rd_q             <= '0;
      no_wb_q          <= 1'b0;
      result           <= '0;
      pend_flags       <= '0;
      flags            <= '0;
      done             <= 1'b0;
    end else begin
      if (accept) begin
        bus.alu_a        <= regs[bus.req_ra];
        bus.alu_b        <= bus.req_imm_en ? bus.req_imm : regs[bus.req_rb];
        bus.alu_sel      <= bus.req_op;
        // carry chains (ADC/SBC) use the C flag committed by the previous op
        bus.alu_carry_in <= flags[3];
        rd_q             <= bus.req_rd;
        no_wb_q          <= (bus.req_op == OP_CMP);
      end
      if (capture) begin
        result     <= bus.alu_out;
        pend_flags <= {bus.alu_carry, bus.alu_sign, bus.alu_overflow, bus.alu_zero};
      end
      if (writeback) begin
        flags <= pend_flags;
        if (!no_wb_q) regs[rd_q] <= result;
      end
      // done coincides with the WB state
      done <= capture;
    end
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer with a small behavioural ALU model.
// ALU codes modelled: 0000 ADD, 0001 ADC, 1011 INC, 1100 CMP (a-b), else pass A.
module tb_alu_sequencer;

  logic        clk;
  logic        reset_n;
  logic        done;
  logic [15:0] result;
  logic [3:0]  flags;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_checks = 0;
  int n_errors = 0;
  logic last_cin;

  alu_sequencer_if #(.WIDTH(16), .AW(3)) bus ();

  alu_sequencer #(.NREGS(8), .WIDTH(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .done     (done),
    .result   (result),
    .flags    (flags),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU
  logic [16:0] alu_sum;
  logic        alu_ovf;
  always_comb begin
    alu_sum = {1'b0, bus.alu_a};
    alu_ovf = 1'b0;
    case (bus.alu_sel)
      4'b0000: begin
        alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        alu_ovf = (bus.alu_a[15] == bus.alu_b[15]) && (alu_sum[15] != bus.alu_a[15]);
      end
      4'b0001: begin
        alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {16'd0, bus.alu_carry_in};
        alu_ovf = (bus.alu_a[15] == bus.alu_b[15]) && (alu_sum[15] != bus.alu_a[15]);
      end
      4'b1011: begin
        alu_sum = {1'b0, bus.alu_a} + 17'd1;
        alu_ovf = (bus.alu_a == 16'h7FFF);
      end
      4'b1100: begin
        alu_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 17'd1;
        alu_ovf = (bus.alu_a[15] != bus.alu_b[15]) && (alu_sum[15] != bus.alu_a[15]);
      end
      default: alu_sum = {1'b0, bus.alu_a};
    endcase
  end
  assign bus.alu_out      = alu_sum[15:0];
  assign bus.alu_carry    = alu_sum[16];
  assign bus.alu_sign     = alu_sum[15];
  assign bus.alu_overflow = alu_ovf;
  assign bus.alu_zero     = (alu_sum[15:0] == 16'd0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic read_reg(input logic [2:0] addr, input logic [15:0] exp, input string tag);
    dbg_addr = addr;
    #1;
    check(tag, {16'd0, dbg_data}, {16'd0, exp});
  endtask

  // Issue one op and check the done pulse timing; returns in IDLE after writeback
  task automatic do_op(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb, input logic ie, input logic [15:0] imm,
                       input string tag);
    int n;
    bus.req_op     = op;
    bus.req_rd     = rd;
    bus.req_ra     = ra;
    bus.req_rb     = rb;
    bus.req_imm_en = ie;
    bus.req_imm    = imm;
    bus.req_valid  = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    last_cin      = bus.alu_carry_in;
    // scramble request fields: they must be ignored after acceptance
    bus.req_op  = 4'($urandom);
    bus.req_rd  = 3'($urandom);
    bus.req_ra  = 3'($urandom);
    bus.req_rb  = 3'($urandom);
    bus.req_imm = 16'($urandom);
    check({tag, "_done_exec"}, {31'd0, done}, 32'd0);
    check({tag, "_ready_exec"}, {31'd0, bus.req_ready}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_wb"}, {31'd0, done}, 32'd1);
    check({tag, "_ready_wb"}, {31'd0, bus.req_ready}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_idle"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, n_acc, bad, n, seen_done;
    int acc [4];

    reset_n        = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 4'd0;
    bus.req_rd     = 3'd0;
    bus.req_ra     = 3'd0;
    bus.req_rb     = 3'd0;
    bus.req_imm_en = 1'b0;
    bus.req_imm    = 16'd0;
    dbg_addr       = 3'd0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // reset state
    for (int i = 0; i < 8; i++) read_reg(3'(i), 16'h0000, $sformatf("rst_reg%0d", i));
    check("rst_flags", {28'd0, flags}, 32'd0);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_alu_a", {16'd0, bus.alu_a}, 32'd0);

    // basic adds
    do_op(4'b0000, 3'd1, 3'd0, 3'd0, 1'b1, 16'h1234, "add_r1");
    read_reg(3'd1, 16'h1234, "r1_val");
    do_op(4'b0000, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0001, "add_r2");
    read_reg(3'd2, 16'h0001, "r2_val");
    do_op(4'b0000, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, "add_r3");
    read_reg(3'd3, 16'h1235, "r3_val");
    check("r3_result", {16'd0, result}, 32'h1235);
    check("r3_flags", {28'd0, flags}, 32'h0);

    // carry generation and ADC consumption
    do_op(4'b0000, 3'd4, 3'd0, 3'd0, 1'b1, 16'hFFFF, "add_r4");
    read_reg(3'd4, 16'hFFFF, "r4_val");
    check("r4_flags", {28'd0, flags}, 32'h4);
    do_op(4'b0000, 3'd5, 3'd4, 3'd0, 1'b1, 16'h0001, "add_r5");
    read_reg(3'd5, 16'h0000, "r5_val");
    check("r5_flags", {28'd0, flags}, 32'h9);
    do_op(4'b0001, 3'd6, 3'd0, 3'd0, 1'b1, 16'h0000, "adc_r6");
    check("adc_cin", {31'd0, last_cin}, 32'd1);
    read_reg(3'd6, 16'h0001, "r6_val");
    check("r6_flags", {28'd0, flags}, 32'h0);

    // compare: flags only, destination untouched
    do_op(4'b0000, 3'd5, 3'd0, 3'd0, 1'b1, 16'hBEEF, "load_r5");
    read_reg(3'd5, 16'hBEEF, "r5_beef");
    do_op(4'b1100, 3'd5, 3'd1, 3'd0, 1'b1, 16'h1234, "cmp");
    check("cmp_cin", {31'd0, last_cin}, 32'd0);
    read_reg(3'd5, 16'hBEEF, "cmp_dest_kept");
    check("cmp_flags", {28'd0, flags}, 32'h9);
    check("cmp_result", {16'd0, result}, 32'h0);

    // reset during EXEC aborts the op
    bus.req_op     = 4'b0000;
    bus.req_rd     = 3'd7;
    bus.req_ra     = 3'd0;
    bus.req_imm_en = 1'b1;
    bus.req_imm    = 16'h5555;
    bus.req_valid  = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("abort_in_exec", {31'd0, bus.req_ready}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    reset_n   = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1;
    end
    check("abort_no_done", seen_done, 0);
    check("abort_ready_after", {31'd0, bus.req_ready}, 32'd1);
    read_reg(3'd7, 16'h0000, "abort_r7");
    read_reg(3'd1, 16'h0000, "abort_r1_cleared");
    check("abort_flags", {28'd0, flags}, 32'h0);

    // back-to-back INC stream with req_valid held high
    do_op(4'b0000, 3'd1, 3'd0, 3'd0, 1'b1, 16'h1234, "reload_r1");
    bus.req_op     = 4'b1011;
    bus.req_rd     = 3'd1;
    bus.req_ra     = 3'd1;
    bus.req_rb     = 3'd0;
    bus.req_imm_en = 1'b0;
    bus.req_imm    = 16'h0000;
    bus.req_valid  = 1'b1;
    c = 0; n_acc = 0; bad = 0;
    while (n_acc < 4 && c < 40) begin
      if (n_acc > 0 && bus.req_ready != (((c - acc[0]) % 3) == 0)) bad++;
      if (bus.req_ready) begin
        acc[n_acc] = c;
        n_acc++;
      end
      @(posedge clk); #1;
      c++;
      if (n_acc == 4) bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
    check("stream_accepts", n_acc, 4);
    check("stream_ready_pattern", bad, 0);
    for (int i = 1; i < 4; i++)
      if (i < n_acc) check($sformatf("stream_gap%0d", i), acc[i] - acc[i-1], 3);
    n = 0;
    while (!done && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check("stream_done_seen", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    read_reg(3'd1, 16'h1238, "stream_r1");
    check("stream_flags", {28'd0, flags}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
